// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the dmem_ctrl data memory.
//   - access size encodings (byte / half / word / reserved)
//   - controller state enum (IDLE, CLEAR)
//   - accessError(): decides whether an accepted request must be rejected
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // A request is rejected for the reserved size, for a half or word that
  // does not sit on its natural boundary, or for an address past the end
  // of storage (range result computed by the caller, which knows the depth).
  function automatic logic accessError(input logic [1:0] size,
                                       input logic [1:0] addrLo,
                                       input logic       outOfRange);
    logic misaligned;
    misaligned = ((size == SZ_HALF) && addrLo[0]) ||
                 ((size == SZ_WORD) && (addrLo != 2'b00));
    return (size == SZ_RSVD) || misaligned || outOfRange;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane steering for dmem_ctrl.
// Ports:
//   size_i     access size (dmem_pkg SZ_* encoding)
//   addrLo_i   byte offset within the word (addr[1:0])
//   unsigned_i 1 = zero-extend loads, 0 = sign-extend
//   wdata_i    right-justified store data
//   rword_i    full 32-bit word read from storage
//   be_o       per-lane byte enables for a store
//   wdata_o    store data replicated so every enabled lane sees its byte
//   rdata_o    selected and extended load result
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addrLo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // Replicating the narrow data across the word means the lane mux is just
  // the byte-enable; no barrel shift is needed on the write path.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addrLo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = addrLo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      SZ_WORD: be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
  end

  // Bring the addressed byte/half down to bit 0, then extend.
  always_comb begin
    shifted = rword_i >> {addrLo_i, 3'b000};
    rdata_o = '0;
    case (size_i)
      SZ_BYTE: rdata_o = unsigned_i ? {24'b0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_o = unsigned_i ? {16'b0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      SZ_WORD: rdata_o = rword_i;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressable data memory for the MEM stage.
// Byte/half/word loads and stores with sign or zero extension, a registered
// read with a one-cycle ack, error reporting for misaligned, reserved-size
// and out-of-range accesses, and a word-per-cycle scrub engine that clears
// storage after reset release or on clear_i.
// Ports:
//   clk_i       clock, rising edge
//   reset_n     asynchronous active-low reset (starts a scrub on release)
//   req_i       request, accepted when req_i && ready_o
//   we_i        1 = store, 0 = load
//   size_i      00 byte, 01 half, 10 word, 11 reserved
//   unsigned_i  load extension select
//   addr_i      byte address
//   wdata_i     right-justified store data
//   clear_i     start a scrub (sampled in IDLE only)
//   ready_o     high in IDLE
//   busy_o      high in CLEAR
//   ack_o       one-cycle pulse the cycle after an accepted request
//   rdata_o     load data, valid with ack_o, otherwise zero
//   err_o       error flag, valid with ack_o, otherwise zero
// Optional build macro DMEM_DEBUG_PORT_EN adds:
//   dbg_addr_i  byte address of a word to peek (bits [1:0] ignored)
//   dbg_data_o  combinational word read, independent of FSM state
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int DBG_ADDR_W  = $clog2(DEPTH_BYTES)
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  clear_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  ack_o,
  output logic [31:0]           rdata_o,
`ifdef DMEM_DEBUG_PORT_EN
  input  logic [DBG_ADDR_W-1:0] dbg_addr_i,
  output logic [31:0]           dbg_data_o,
`endif
  output logic                  err_o
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int WA_W  = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH_BYTES);
  localparam logic [WA_W-1:0]   LAST_WORD = WA_W'(WORDS - 1);

  logic [3:0][7:0] mem_q [WORDS];

  state_e          state_q, state_d;
  logic [WA_W-1:0] clrPtr_q, clrPtr_d;
  logic            ack_q, err_q;
  logic [31:0]     rdata_q;

  logic            accept;
  logic            reqErr;
  logic            doStore;
  logic [WA_W-1:0] wordIdx;
  logic [31:0]     rword;
  logic [31:0]     loadData;
  logic [31:0]     storeData;
  logic [3:0]      be;

  assign accept  = req_i && (state_q == IDLE);
  assign reqErr  = accessError(size_i, addr_i[1:0], addr_i >= DEPTH_A);
  assign doStore = accept && we_i && !reqErr;
  // Out-of-range addresses alias here, but reqErr blocks both the write and
  // the returned data, so the alias is never observable.
  assign wordIdx = addr_i[WA_W+1:2];
  assign rword   = mem_q[wordIdx];

  dmem_lane_align u_lane_align (
    .size_i     (size_i),
    .addrLo_i   (addr_i[1:0]),
    .unsigned_i (unsigned_i),
    .wdata_i    (wdata_i),
    .rword_i    (rword),
    .be_o       (be),
    .wdata_o    (storeData),
    .rdata_o    (loadData)
  );

  // Storage has no reset; the scrub owns the write port while in CLEAR,
  // which is why requests are refused there.
  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR) begin
      mem_q[clrPtr_q] <= '0;
    end else if (doStore) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_q[wordIdx][k] <= storeData[8*k +: 8];
      end
    end
  end

  // clear_i only matters in IDLE; in CLEAR the pointer just walks to the
  // last word and drops back to IDLE on the edge that writes it.
  always_comb begin
    state_d  = state_q;
    clrPtr_d = clrPtr_q;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d  = CLEAR;
          clrPtr_d = '0;
        end
      end
      CLEAR: begin
        clrPtr_d = clrPtr_q + WA_W'(1);
        if (clrPtr_q == LAST_WORD) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= CLEAR;
      clrPtr_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      clrPtr_q <= clrPtr_d;
      ack_q    <= accept;
      err_q    <= accept && reqErr;
      rdata_q  <= (accept && !we_i && !reqErr) ? loadData : '0;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q == CLEAR);
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

`ifdef DMEM_DEBUG_PORT_EN
  logic [1:0] unusedDbgLo;
  assign unusedDbgLo = dbg_addr_i[1:0];
  assign dbg_data_o  = mem_q[dbg_addr_i[DBG_ADDR_W-1:2]];
`else
  localparam int unusedDbgAddrW = DBG_ADDR_W;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl (default 1024-byte depth).
// A byte-array reference model computes expected load data and errors from
// the access rules; directed scenarios plus a randomized pipelined run are
// compared against it. Build with DMEM_DEBUG_PORT_EN to also check the
// debug peek port.
`timescale 1ns/1ps
module tb_dmem_ctrl;

  localparam int DEPTH = 1024;
  localparam int WORDS = DEPTH / 4;

  logic        clk   = 1'b0;
  logic        rstN  = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic        uns   = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        clr   = 1'b0;
  logic        ready, busy, ack, err;
  logic [31:0] rdata;
`ifdef DMEM_DEBUG_PORT_EN
  logic [9:0]  dbgAddr = '0;
  logic [31:0] dbgData;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] modelMem [DEPTH];

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
    .clk_i      (clk),
    .reset_n    (rstN),
    .req_i      (req),
    .we_i       (we),
    .size_i     (size),
    .unsigned_i (uns),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .clear_i    (clr),
    .ready_o    (ready),
    .busy_o     (busy),
    .ack_o      (ack),
    .rdata_o    (rdata),
`ifdef DMEM_DEBUG_PORT_EN
    .dbg_addr_i (dbgAddr),
    .dbg_data_o (dbgData),
`endif
    .err_o      (err)
  );

  // Reference model: a flat byte array, little-endian multi-byte accesses.
  task automatic modelAccess(input logic mWe, input logic [1:0] mSize,
                             input logic mUns, input logic [31:0] mAddr,
                             input logic [31:0] mWdata,
                             output logic mErr, output logic [31:0] mRdata);
    int n;
    logic [63:0] v;
    n = (mSize == 2'd0) ? 1 : (mSize == 2'd1) ? 2 : 4;
    mErr = (mSize == 2'd3) || (mAddr >= 32'(DEPTH)) || ((mAddr % 32'(n)) != 0);
    mRdata = '0;
    if (!mErr) begin
      if (mWe) begin
        for (int i = 0; i < n; i++) modelMem[int'(mAddr) + i] = mWdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v + (64'(modelMem[int'(mAddr) + i]) << (8*i));
        mRdata = v[31:0];
        if (!mUns && n < 4 && v[8*n-1]) mRdata = mRdata | (32'hFFFF_FFFF << (8*n));
      end
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < DEPTH; i++) modelMem[i] = 8'h00;
  endtask

  task automatic sendReq(input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
  endtask

  task automatic test_reset();
    int cnt;
    rstN = 1'b0;
    #12;
    testsRun++;
    if ({busy, ready, ack, err, rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_state busy/ready/ack/err/rdata=%b/%b/%b/%b/%h want 1/0/0/0/00000000",
               busy, ready, ack, err, rdata);
    end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    testsRun++;
    if (cnt != WORDS || ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_scrub_len busy_cycles=%0d ready=%b want %0d/1", cnt, ready, WORDS);
    end
    modelClear();
  endtask

  task automatic test_init_zero();
    sendReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    req = 1'b0;
    testsRun++;
    if ({ack, err, rdata} !== {1'b1, 1'b0, 32'h0}) begin
      testsFailed++;
      $display("[TB] FAIL init_zero ack/err/rdata=%b/%b/%h want 1/0/00000000", ack, err, rdata);
    end
  endtask

  task automatic test_loads();
    logic        e;
    logic [31:0] r;
    logic [1:0]  sz  [3] = '{2'b00, 2'b00, 2'b01};
    logic        un  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ad  [3] = '{32'h21, 32'h21, 32'h22};
    logic [31:0] exp [3] = '{32'hFFFF_FFBE, 32'h0000_00BE, 32'hFFFF_DEAD};
    sendReq(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF);
    modelAccess(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, e, r);
    @(negedge clk);
    req = 1'b0;
    testsRun++;
    if ({ack, err, rdata} !== {1'b1, 1'b0, 32'h0}) begin
      testsFailed++;
      $display("[TB] FAIL store_ack ack/err/rdata=%b/%b/%h want 1/0/00000000", ack, err, rdata);
    end
    for (int i = 0; i < 3; i++) begin
      sendReq(1'b0, sz[i], un[i], ad[i], 32'h0);
      @(negedge clk);
      req = 1'b0;
      testsRun++;
      if ({ack, err, rdata} !== {1'b1, 1'b0, exp[i]}) begin
        testsFailed++;
        $display("[TB] FAIL load_ext_%0d ack/err/rdata=%b/%b/%h want 1/0/%h", i, ack, err, rdata, exp[i]);
      end
    end
  endtask

`ifdef DMEM_DEBUG_PORT_EN
  task automatic test_debug();
    dbgAddr = 10'h22;
    #1;
    testsRun++;
    if (dbgData !== 32'hDEAD_BEEF) begin
      testsFailed++;
      $display("[TB] FAIL dbg_peek got=%h want deadbeef", dbgData);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic        e;
    logic [31:0] r;
    sendReq(1'b1, 2'b00, 1'b0, 32'h23, 32'h0000_007F);
    modelAccess(1'b1, 2'b00, 1'b0, 32'h23, 32'h0000_007F, e, r);
    sendReq(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    testsRun++;
    if ({ack, err, rdata} !== {1'b1, 1'b0, 32'h0}) begin
      testsFailed++;
      $display("[TB] FAIL b2b_store_ack ack/err/rdata=%b/%b/%h want 1/0/00000000", ack, err, rdata);
    end
    @(negedge clk);
    req = 1'b0;
    testsRun++;
    if ({ack, err, rdata} !== {1'b1, 1'b0, 32'h7FAD_BEEF}) begin
      testsFailed++;
      $display("[TB] FAIL b2b_load ack/err/rdata=%b/%b/%h want 1/0/7fadbeef", ack, err, rdata);
    end
  endtask

  task automatic test_errors();
    logic        e;
    logic [31:0] r;
    logic        ew [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  es [6] = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10};
    logic [31:0] ea [6] = '{32'h22, 32'h25, 32'h400, 32'h0, 32'h24, 32'h424};
    logic [31:0] ed [6] = '{32'h0, 32'hFFFF, 32'h0, 32'h0, 32'h0, 32'hAAAA_AAAA};
    sendReq(1'b1, 2'b10, 1'b0, 32'h24, 32'h1122_3344);
    modelAccess(1'b1, 2'b10, 1'b0, 32'h24, 32'h1122_3344, e, r);
    for (int i = 0; i < 6; i++) begin
      sendReq(ew[i], es[i], 1'b0, ea[i], ed[i]);
      @(negedge clk);
      req = 1'b0;
      testsRun++;
      if ({ack, err, rdata} !== {1'b1, 1'b1, 32'h0}) begin
        testsFailed++;
        $display("[TB] FAIL err_case_%0d ack/err/rdata=%b/%b/%h want 1/1/00000000", i, ack, err, rdata);
      end
    end
    modelAccess(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, e, r);
    sendReq(1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    @(negedge clk);
    req = 1'b0;
    testsRun++;
    if ({ack, err, rdata} !== {1'b1, 1'b0, r} || r !== 32'h1122_3344) begin
      testsFailed++;
      $display("[TB] FAIL err_no_write got=%h/%b want 11223344/0", rdata, err);
    end
  endtask

  task automatic test_random();
    logic        prevValid = 1'b0;
    logic        prevErr   = 1'b0;
    logic [31:0] prevRdata = '0;
    logic        doReq, w, u, e;
    logic [1:0]  s;
    logic [31:0] a, d, r;
    int          pick;
    for (int i = 0; i <= 300; i++) begin
      doReq = ($urandom_range(0, 3) != 0) && (i < 300);
      w     = 1'($urandom_range(0, 1));
      s     = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      u     = 1'($urandom_range(0, 1));
      pick  = $urandom_range(0, 15);
      a     = (pick == 0) ? 32'(DEPTH + $urandom_range(0, 255)) :
              (pick == 1) ? 32'($urandom_range(0, DEPTH - 1)) : 32'($urandom_range(0, 63));
      d     = $urandom;
      @(negedge clk);
      if (i > 0) begin
        testsRun++;
        if (ack !== prevValid || err !== prevErr || rdata !== prevRdata) begin
          testsFailed++;
          $display("[TB] FAIL rand_%0d ack/err/rdata=%b/%b/%h want %b/%b/%h",
                   i, ack, err, rdata, prevValid, prevErr, prevRdata);
        end
      end
      req = doReq; we = w; size = s; uns = u; addr = a; wdata = d;
      prevValid = doReq;
      prevErr   = 1'b0;
      prevRdata = '0;
      if (doReq) begin
        modelAccess(w, s, u, a, d, e, r);
        prevErr   = e;
        prevRdata = r;
      end
    end
    req = 1'b0;
  endtask

  task automatic test_scrub();
    int          cnt;
    logic        e;
    logic [31:0] r;
    logic [31:0] expDbg;
    modelAccess(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, e, expDbg);
`ifdef DMEM_DEBUG_PORT_EN
    dbgAddr = 10'h22;
`endif
    @(negedge clk);
    clr = 1'b1; req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h8; wdata = 32'h1234_5678;
    @(negedge clk);
    clr = 1'b0; req = 1'b0;
    testsRun++;
    if ({ack, err, rdata, busy} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL scrub_store_ack ack/err/rdata/busy=%b/%b/%h/%b want 1/0/00000000/1",
               ack, err, rdata, busy);
    end
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
`ifdef DMEM_DEBUG_PORT_EN
      if (cnt == 3) begin
        testsRun++;
        if (dbgData !== expDbg) begin
          testsFailed++;
          $display("[TB] FAIL dbg_in_clear got=%h want %h", dbgData, expDbg);
        end
      end
`endif
      if (cnt == 11) begin
        testsRun++;
        if (ack !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL req_in_clear ack=%b want 0", ack);
        end
        req = 1'b0;
      end
      if (cnt == 10) begin
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h8;
      end
      @(negedge clk);
    end
    testsRun++;
    if (cnt != WORDS || ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL scrub_len busy_cycles=%0d ready=%b want %0d/1", cnt, ready, WORDS);
    end
    modelClear();
    modelAccess(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, e, r);
    sendReq(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    req = 1'b0;
    testsRun++;
    if ({ack, err, rdata} !== {1'b1, 1'b0, r}) begin
      testsFailed++;
      $display("[TB] FAIL scrub_cleared ack/err/rdata=%b/%b/%h want 1/0/%h", ack, err, rdata, r);
    end
  endtask

  task automatic test_clear_mid_scrub();
    int cnt;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      clr = (cnt == 50);
      @(negedge clk);
    end
    clr = 1'b0;
    testsRun++;
    if (cnt != WORDS) begin
      testsFailed++;
      $display("[TB] FAIL clear_ignored busy_cycles=%0d want %0d", cnt, WORDS);
    end
  endtask

  task automatic test_reset_mid_scrub();
    int          cnt;
    logic        e;
    logic [31:0] r;
    sendReq(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D);
    @(negedge clk);
    req = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    rstN = 1'b0;
    #1;
    testsRun++;
    if ({busy, ready, ack} !== {1'b1, 1'b0, 1'b0} || cnt != 100) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid busy/ready/ack=%b/%b/%b cnt=%0d want 1/0/0 cnt=100",
               busy, ready, ack, cnt);
    end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    testsRun++;
    if (cnt != WORDS || ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_restart busy_cycles=%0d ready=%b want %0d/1", cnt, ready, WORDS);
    end
    modelClear();
    modelAccess(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, e, r);
    sendReq(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    @(negedge clk);
    req = 1'b0;
    testsRun++;
    if ({ack, err, rdata} !== {1'b1, 1'b0, r}) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_cleared ack/err/rdata=%b/%b/%h want 1/0/%h", ack, err, rdata, r);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_init_zero();
    test_loads();
`ifdef DMEM_DEBUG_PORT_EN
    test_debug();
`endif
    test_back_to_back();
    test_errors();
    test_random();
    test_scrub();
    test_clear_mid_scrub();
    test_reset_mid_scrub();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
